polar_simd_unit: RTL and testbench
==================================

# polar_simd_unit

- Pipelined, multi-lane successor to the scalar polar kernel operations (F, G, R) in the integer ALU.
- Treats each operand as `LANES = XLEN/QTF_SIZE` packed signed LLRs and applies the selected successive-cancellation kernel to every lane in parallel.
- Has a valid/ready handshake, a two-stage pipeline with backpressure, flush, and per-lane saturation reporting.
- Sits beside the ALU as a separate functional unit fed by issue and drained by writeback.

## Interface
Parameters:
- `XLEN`, default `riscv::XLEN`: operand/result width.
- `QTF_SIZE`, default 8: LLR width in bits. Legal range 4..16; must divide `XLEN`.
- `TRANS_ID_BITS`, default `ariane_pkg::TRANS_ID_BITS`: width of the transaction tag.

Ports:
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset. Asynchronous, active-low.
- `flush_i`  in  1: discard all in-flight operations.
- `valid_i`  in  1: request valid.
- `ready_o`  out  1: unit accepts the request this cycle.
- `op_i`  in  `polar_op_t`: operation, one of PL_F, PL_G, PL_R.
- `operand_a_i`  in  XLEN: packed LLR lanes a.
- `operand_b_i`  in  XLEN: packed LLR lanes b.
- `mask_i`  in  LANES: per lane, the G partial-sum bit u or the R frozen flag.
- `trans_id_i`  in  TRANS_ID_BITS: tag.
- `valid_o`  out  1: result valid.
- `ready_i`  in  1: consumer accepts the result.
- `result_o`  out  XLEN: packed result.
- `trans_id_o`  out  TRANS_ID_BITS: tag of the result.
- `sat_o`  out  LANES: per-lane saturation flag of the result.
- `sat_cnt_o`  out  32: saturation event counter. Present only when the macro in Configuration is defined.
- `sat_clr_i`  in  1: clear the counter. Present only when the macro in Configuration is defined.

## Operation
Definitions, per lane i (bits `[i*Q +: Q]`):
- MAX = 2^(Q-1)-1.
- `sat(x)` clamps a Q+1-bit signed value to the range [-MAX, +MAX]. The pattern -2^(Q-1) is never produced.
- `abs(x)` = |x| clamped to MAX.

Kernels:
- PL_F: r = (sign(a) XOR sign(b)) ? -min(abs(a), abs(b)) : +min(abs(a), abs(b)).
  - sat_o[i] = 1 when either input equals -2^(Q-1).
- PL_G: r = mask_i[i] ? sat(b-a) : sat(a+b).
  - The sum or difference is computed at Q+1 bits.
  - sat_o[i] = 1 when clamping changed the value.
- PL_R: hard decision bit h[i] = mask_i[i] ? 0 : (a<0).
  - result_o = zero-extended {h[LANES-1..0]}.
  - sat_o = 0.

Pipeline and handshake:
- Stage 1 registers the operands, op, mask and tag. It also registers the pre-saturation sums and the absolute values.
- Stage 2 registers the saturated and selected result, `sat_o` and the tag.
- A stage advances when it is valid and the following stage is empty or advancing. Stage 2 advances on `valid_o && ready_i`.
- `ready_o = !s1_valid || s1_advance`. It is combinationally dependent on `ready_i`.
- While `valid_o && !ready_i`, `result_o`, `trans_id_o` and `sat_o` hold stable.
- Results leave in issue order. At most two operations are in flight.

Reset and flush:
- Reset clears both stage valids and zeroes `result_o`, `trans_id_o`, `sat_o` and `sat_cnt_o`.
- Reset mid-operation drops all in-flight work.
- `flush_i` clears both stage valids at the next edge. A request presented in the same cycle as `flush_i` is not accepted, and `ready_o` is 0 during flush.
- Data registers need no clearing on flush.

## Timing
- Latency: 2 cycles from acceptance to `valid_o`, with no stall.
- Throughput: 1 operation per cycle while `ready_i` = 1.
- No combinational path from `valid_i` or the operands to any output.

## Configuration
- Macro: `POLAR_SAT_CNT_EN`.
- Defined:
  - `sat_cnt_o` increments by popcount(`sat_o`) on each stage-2 handshake (`valid_o && ready_i`).
  - The counter saturates at 0xFFFF_FFFF and does not wrap.
  - `sat_clr_i` zeroes the counter and has priority over a same-cycle increment.
- Not defined: the `sat_cnt_o` and `sat_clr_i` ports and the counter logic are absent. All other behaviour is identical.

## Structure
- Package `polar_pkg` holds:
  - `polar_op_t` {PL_F, PL_G, PL_R};
  - the default `QTF_SIZE`;
  - the function `polar_lanes(xlen, q)`;
  - `localparam` MAX as a function of Q.
- Sub-module `polar_lane`: one combinational lane kernel (abs, min, sign, Q+1-bit add/sub, saturation). It is instantiated LANES times in a generate loop and split across the stage-1/stage-2 boundary.
- Top module: pipeline registers, handshake, R-bit packing, optional counter.

## Test plan
All scenarios use Q=8 and XLEN=64.
- PL_F, lane 0: a=0x05, b=0xFD → 0xFD, sat 0. Lane 1: a=0x80, b=0x7F → 0x81, sat_o[1] = 1.
- PL_G: lane 0 with u=0, a=0x70, b=0x70 → 0x7F, sat 1. Lane 1 with u=1, a=0x10, b=0x05 → 0xF5, sat 0. Lane 2 with u=1, a=0x7F, b=0x81 → 0x81, sat 1.
- PL_R: lanes a = {..., 0x01, 0xFF}, mask = 0b10 on lanes 0 and 1, with lanes 2..7 positive and unmasked → result 0x1. Same lanes with mask=0 → 0x1. With a lane 1 = 0xFF and mask = 0b10 → 0x1.
- Backpressure: issue 3 back-to-back ops with `ready_i` = 0 → `ready_o` drops after 2 are accepted and outputs hold stable. Then set `ready_i` = 1 → results emerge in order with tags 1, 2, 3, one per cycle.
- Flush with 2 ops in flight → `valid_o` = 0 from the next cycle and no stale result appears. Assert `rst_ni` mid-stream → all outputs read 0 immediately.
- With `POLAR_SAT_CNT_EN`: 4 accepted PL_G ops, each with 8 saturating lanes → `sat_cnt_o` = 32. Assert `sat_clr_i` in the same cycle as a further saturating handshake → counter = 0.

Source files
------------

// File: rtl/polar_pkg.sv
// Shared types and helpers for the polar SIMD unit: op encoding, default sizes,
// lane-count and LLR magnitude-limit helpers.
package polar_pkg;

    typedef enum logic [1:0] {
        PL_F = 2'd0,
        PL_G = 2'd1,
        PL_R = 2'd2
    } polar_op_t;

    localparam int QTF_SIZE_DEF      = 8;
    localparam int XLEN_DEF          = 64;
    localparam int TRANS_ID_BITS_DEF = 4;

    function automatic int polar_lanes(input int xlen, input int q);
        return xlen / q;
    endfunction

    // Largest magnitude an LLR may carry; the most negative pattern is never emitted.
    function automatic int polar_max(input int q);
        return (1 << (q - 1)) - 1;
    endfunction

    localparam int MAX = polar_max(QTF_SIZE_DEF);

endpackage

// File: rtl/polar_simd_unit_if.sv
// Issue/writeback handshake bundle for polar_simd_unit; slave = unit side.
// Counter signals exist only when POLAR_SAT_CNT_EN is defined.
interface polar_simd_unit_if
    import polar_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter int QTF_SIZE      = QTF_SIZE_DEF,
    parameter int TRANS_ID_BITS = TRANS_ID_BITS_DEF
) ();
    localparam int LANES = polar_lanes(XLEN, QTF_SIZE);

    logic                     flush_i;
    logic                     valid_i;
    logic                     ready_o;
    polar_op_t                op_i;
    logic [XLEN-1:0]          operand_a_i;
    logic [XLEN-1:0]          operand_b_i;
    logic [LANES-1:0]         mask_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [XLEN-1:0]          result_o;
    logic [TRANS_ID_BITS-1:0] trans_id_o;
    logic [LANES-1:0]         sat_o;
`ifdef POLAR_SAT_CNT_EN
    logic [31:0]              sat_cnt_o;
    logic                     sat_clr_i;
`endif

    modport slave (
        input  flush_i, valid_i, op_i, operand_a_i, operand_b_i, mask_i, trans_id_i, ready_i,
        output ready_o, valid_o, result_o, trans_id_o, sat_o
`ifdef POLAR_SAT_CNT_EN
        , input sat_clr_i, output sat_cnt_o
`endif
    );

    modport master (
        output flush_i, valid_i, op_i, operand_a_i, operand_b_i, mask_i, trans_id_i, ready_i,
        input  ready_o, valid_o, result_o, trans_id_o, sat_o
`ifdef POLAR_SAT_CNT_EN
        , output sat_clr_i, input sat_cnt_o
`endif
    );

endinterface

// File: rtl/polar_lane.sv
// One LLR lane of the SC kernels, split into a front half (abs, sign, Q+1-bit sum/diff)
// feeding stage 1 and a back half (min, negate, saturate, select) feeding stage 2.
// Purely combinational; no latency and no backpressure of its own.
module polar_lane
    import polar_pkg::*;
#(
    parameter int Q = QTF_SIZE_DEF
) (
    input  logic [Q-1:0] a,
    input  logic [Q-1:0] b,
    output logic [Q:0]   sum,
    output logic [Q:0]   diff,
    output logic [Q-1:0] abs_a,
    output logic [Q-1:0] abs_b,
    output logic         sgn_x,
    output logic         has_min,
    input  polar_op_t    op,
    input  logic         mask,
    input  logic [Q:0]   r_sum,
    input  logic [Q:0]   r_diff,
    input  logic [Q-1:0] r_abs_a,
    input  logic [Q-1:0] r_abs_b,
    input  logic         r_sgn_x,
    input  logic         r_has_min,
    output logic [Q-1:0] res,
    output logic         sat
);
    localparam logic [Q-1:0] MOST_NEG = {1'b1, {(Q-1){1'b0}}};
    localparam logic [Q:0]   POS_LIM  = (Q+1)'(polar_max(Q));
    localparam logic [Q:0]   NEG_LIM  = ~POS_LIM + (Q+1)'(1);

    function automatic logic [Q-1:0] abs_q(input logic [Q-1:0] x);
        if (x == MOST_NEG) return POS_LIM[Q-1:0];
        else if (x[Q-1])   return -x;
        else               return x;
    endfunction

    assign sum     = {a[Q-1], a} + {b[Q-1], b};
    assign diff    = {b[Q-1], b} - {a[Q-1], a};
    assign abs_a   = abs_q(a);
    assign abs_b   = abs_q(b);
    assign sgn_x   = a[Q-1] ^ b[Q-1];
    assign has_min = (a == MOST_NEG) || (b == MOST_NEG);

    logic [Q-1:0] m;
    logic [Q:0]   g;

    always_comb begin
        res = '0;
        sat = 1'b0;
        m   = (r_abs_a < r_abs_b) ? r_abs_a : r_abs_b;
        g   = mask ? r_diff : r_sum;
        case (op)
            PL_F: begin
                res = r_sgn_x ? -m : m;
                sat = r_has_min;
            end
            PL_G: begin
                if ($signed(g) > $signed(POS_LIM)) begin
                    res = POS_LIM[Q-1:0];
                    sat = 1'b1;
                end else if ($signed(g) < $signed(NEG_LIM)) begin
                    res = NEG_LIM[Q-1:0];
                    sat = 1'b1;
                end else begin
                    res = g[Q-1:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/polar_simd_unit.sv
// Multi-lane polar SC kernel unit (F, G, R) on packed signed LLRs; optional counter via POLAR_SAT_CNT_EN.
// Latency 2 cycles, 1 op/cycle; two pipeline stages, at most two ops in flight.
// Backpressure: stage 2 holds while valid_o && !ready_i; ready_o = !flush && (!s1 || s1 advancing).
module polar_simd_unit
    import polar_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter int QTF_SIZE      = QTF_SIZE_DEF,
    parameter int TRANS_ID_BITS = TRANS_ID_BITS_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    polar_simd_unit_if.slave bus
);
    localparam int Q     = QTF_SIZE;
    localparam int LANES = polar_lanes(XLEN, QTF_SIZE);

    if (QTF_SIZE < 4 || QTF_SIZE > 16 || (XLEN % QTF_SIZE) != 0) begin : g_bad_cfg
        $error("polar_simd_unit: QTF_SIZE must be 4..16 and divide XLEN");
    end

    // Front-half lane outputs (from live operands)
    logic [LANES-1:0][Q:0]   f_sum, f_diff;
    logic [LANES-1:0][Q-1:0] f_abs_a, f_abs_b;
    logic [LANES-1:0]        f_sgn_x, f_has_min;

    // Stage 1
    logic                     s1_vld;
    polar_op_t                s1_op;
    logic [LANES-1:0]         s1_mask;
    logic [TRANS_ID_BITS-1:0] s1_tag;
    logic [LANES-1:0][Q:0]    s1_sum, s1_diff;
    logic [LANES-1:0][Q-1:0]  s1_abs_a, s1_abs_b;
    logic [LANES-1:0]         s1_sgn_x, s1_has_min, s1_a_neg;

    // Back-half lane outputs (from stage 1)
    logic [LANES-1:0][Q-1:0]  b_res;
    logic [LANES-1:0]         b_sat;

    // Stage 2
    logic                     s2_vld;
    logic [XLEN-1:0]          s2_res;
    logic [TRANS_ID_BITS-1:0] s2_tag;
    logic [LANES-1:0]         s2_sat;

    logic s1_adv, s2_adv, accept;
    logic [LANES-1:0] r_bits;
    logic [XLEN-1:0]  nxt_res;
    logic [LANES-1:0] nxt_sat;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        polar_lane #(.Q(Q)) u_lane (
            .a         (bus.operand_a_i[i*Q +: Q]),
            .b         (bus.operand_b_i[i*Q +: Q]),
            .sum       (f_sum[i]),
            .diff      (f_diff[i]),
            .abs_a     (f_abs_a[i]),
            .abs_b     (f_abs_b[i]),
            .sgn_x     (f_sgn_x[i]),
            .has_min   (f_has_min[i]),
            .op        (s1_op),
            .mask      (s1_mask[i]),
            .r_sum     (s1_sum[i]),
            .r_diff    (s1_diff[i]),
            .r_abs_a   (s1_abs_a[i]),
            .r_abs_b   (s1_abs_b[i]),
            .r_sgn_x   (s1_sgn_x[i]),
            .r_has_min (s1_has_min[i]),
            .res       (b_res[i]),
            .sat       (b_sat[i])
        );
    end

    assign s2_adv      = s2_vld & bus.ready_i;
    assign s1_adv      = s1_vld & (~s2_vld | s2_adv);
    assign bus.ready_o = ~bus.flush_i & (~s1_vld | s1_adv);
    assign accept      = bus.valid_i & bus.ready_o;

    // R packs one hard-decision bit per lane into the low bits of the result.
    assign r_bits  = ~s1_mask & s1_a_neg;
    assign nxt_res = (s1_op == PL_R) ? XLEN'(r_bits) : b_res;
    assign nxt_sat = (s1_op == PL_R) ? '0 : b_sat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else if (bus.flush_i) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            if (accept)      s1_vld <= 1'b1;
            else if (s1_adv) s1_vld <= 1'b0;
            if (s1_adv)      s2_vld <= 1'b1;
            else if (s2_adv) s2_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_op      <= PL_F;
            s1_mask    <= '0;
            s1_tag     <= '0;
            s1_sum     <= '0;
            s1_diff    <= '0;
            s1_abs_a   <= '0;
            s1_abs_b   <= '0;
            s1_sgn_x   <= '0;
            s1_has_min <= '0;
            s1_a_neg   <= '0;
        end else if (accept) begin
            s1_op      <= bus.op_i;
            s1_mask    <= bus.mask_i;
            s1_tag     <= bus.trans_id_i;
            s1_sum     <= f_sum;
            s1_diff    <= f_diff;
            s1_abs_a   <= f_abs_a;
            s1_abs_b   <= f_abs_b;
            s1_sgn_x   <= f_sgn_x;
            s1_has_min <= f_has_min;
            for (int i = 0; i < LANES; i++) s1_a_neg[i] <= bus.operand_a_i[i*Q + Q - 1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_res <= '0;
            s2_tag <= '0;
            s2_sat <= '0;
        end else if (s1_adv) begin
            s2_res <= nxt_res;
            s2_tag <= s1_tag;
            s2_sat <= nxt_sat;
        end
    end

    assign bus.valid_o    = s2_vld;
    assign bus.result_o   = s2_res;
    assign bus.trans_id_o = s2_tag;
    assign bus.sat_o      = s2_sat;

`ifdef POLAR_SAT_CNT_EN
    logic [31:0] sat_cnt;
    logic [32:0] cnt_sum;

    assign cnt_sum = {1'b0, sat_cnt} + 33'($countones(s2_sat));

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)             sat_cnt <= '0;
        else if (bus.sat_clr_i)  sat_cnt <= '0;
        else if (s2_adv)         sat_cnt <= cnt_sum[32] ? '1 : cnt_sum[31:0];
    end

    assign bus.sat_cnt_o = sat_cnt;
`endif

endmodule

// File: tb/tb_polar_simd_unit.sv
// Scoreboard bench for polar_simd_unit (Q=8, XLEN=64): directed kernel vectors,
// backpressure, flush, reset and randomized traffic against an integer reference model.
module tb_polar_simd_unit;
    import polar_pkg::*;

    localparam int XLEN = 64;
    localparam int Q    = 8;
    localparam int TB   = 4;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  tag;
        logic [7:0]  sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    bit   rand_rdy = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    polar_simd_unit_if #(.XLEN(XLEN), .QTF_SIZE(Q), .TRANS_ID_BITS(TB)) bus ();

    polar_simd_unit #(.XLEN(XLEN), .QTF_SIZE(Q), .TRANS_ID_BITS(TB)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Reference: each lane treated as a plain signed integer in [-128, 127].
    function automatic exp_t model(input polar_op_t op, input logic [63:0] a, input logic [63:0] b,
                                   input logic [7:0] m, input logic [3:0] tag);
        exp_t e;
        logic signed [7:0] ta, tb;
        int ai, bi, aa, bb, mn, x, c;
        e.res = '0;
        e.sat = '0;
        e.tag = tag;
        for (int i = 0; i < 8; i++) begin
            ta = a[i*8 +: 8];
            tb = b[i*8 +: 8];
            ai = ta;
            bi = tb;
            if (op == PL_F) begin
                aa = (ai < 0) ? -ai : ai;
                bb = (bi < 0) ? -bi : bi;
                if (aa > 127) aa = 127;
                if (bb > 127) bb = 127;
                mn = (aa < bb) ? aa : bb;
                c  = ((ai < 0) != (bi < 0)) ? -mn : mn;
                e.res[i*8 +: 8] = 8'(c);
                e.sat[i] = (ai == -128) || (bi == -128);
            end else if (op == PL_G) begin
                x = m[i] ? (bi - ai) : (ai + bi);
                c = (x > 127) ? 127 : ((x < -127) ? -127 : x);
                e.res[i*8 +: 8] = 8'(c);
                e.sat[i] = (c != x);
            end else begin
                e.res[i] = !m[i] && (ai < 0);
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every stage-2 handshake must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && bus.valid_o && bus.ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_result: got tag %0d result %h, expected nothing",
                             bus.trans_id_o, bus.result_o);
                end else begin
                    e = exp_q.pop_front();
                    check("result", bus.result_o, e.res);
                    check("tag", 64'(bus.trans_id_o), 64'(e.tag));
                    check("sat", 64'(bus.sat_o), 64'(e.sat));
                end
            end
        end
    end

    task automatic issue(input polar_op_t op, input logic [63:0] a, input logic [63:0] b,
                         input logic [7:0] m, input logic [3:0] tag);
        int  n = 0;
        bit  done = 1'b0;
        @(negedge clk);
        bus.valid_i     = 1'b1;
        bus.op_i        = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        bus.mask_i      = m;
        bus.trans_id_i  = tag;
        while (!done) begin
            if (rand_rdy) bus.ready_i = ($urandom_range(0, 3) != 0);
            #4;
            if (bus.ready_o) begin
                exp_q.push_back(model(op, a, b, m, tag));
                done = 1'b1;
            end else begin
                n++;
                if (n > 100) begin
                    checks++;
                    fails++;
                    $display("FAIL issue_timeout: got ready_o 0 for 100 cycles expected 1 (tag %0d)", tag);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.valid_i = 1'b0;
            if (rand_rdy) bus.ready_i = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drain();
        int n = 0;
        rand_rdy = 1'b0;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d results outstanding expected 0", exp_q.size());
        end
    endtask

    initial begin
        exp_t e0;
        logic [3:0] tag;
        bus.flush_i     = 1'b0;
        bus.valid_i     = 1'b0;
        bus.op_i        = PL_F;
        bus.operand_a_i = '0;
        bus.operand_b_i = '0;
        bus.mask_i      = '0;
        bus.trans_id_i  = '0;
        bus.ready_i     = 1'b1;
`ifdef POLAR_SAT_CNT_EN
        bus.sat_clr_i   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_result", bus.result_o, 64'd0);
        check("rst_tag", 64'(bus.trans_id_o), 64'd0);
        check("rst_sat", 64'(bus.sat_o), 64'd0);
        check("rst_ready", 64'(bus.ready_o), 64'd1);
        rst_n = 1'b1;

        // Directed kernel vectors
        issue(PL_F, 64'h1111_1111_1111_8005, 64'h2222_2222_2222_7FFD, 8'h00, 4'd1);
        issue(PL_G, 64'h0000_0000_007F_1070, 64'h0000_0000_0081_0570, 8'h06, 4'd2);
        issue(PL_R, 64'h0101_0101_0101_01FF, 64'h0, 8'h02, 4'd3);
        issue(PL_R, 64'h0101_0101_0101_01FF, 64'h0, 8'h00, 4'd4);
        issue(PL_R, 64'h0101_0101_0101_FFFF, 64'h0, 8'h02, 4'd5);
        drain();

        // Backpressure: two accepted, third refused, outputs frozen
        bus.ready_i = 1'b0;
        issue(PL_F, 64'h8070_6050_4030_2010, 64'hF0E0_D0C0_B0A0_9080, 8'h00, 4'd1);
        issue(PL_G, 64'h7070_7070_7070_7070, 64'h7070_7070_7070_7070, 8'h00, 4'd2);
        @(negedge clk);
        bus.op_i        = PL_R;
        bus.operand_a_i = 64'h80FF_0101_8001_01FF;
        bus.mask_i      = 8'h00;
        bus.trans_id_i  = 4'd3;
        #4;
        check("bp_ready_low", 64'(bus.ready_o), 64'd0);
        check("bp_valid", 64'(bus.valid_o), 64'd1);
        e0 = exp_q[0];
        repeat (3) begin
            check("bp_tag_hold", 64'(bus.trans_id_o), 64'd1);
            check("bp_result_hold", bus.result_o, e0.res);
            check("bp_sat_hold", 64'(bus.sat_o), 64'(e0.sat));
            @(negedge clk);
            #4;
        end
        @(negedge clk);
        bus.ready_i = 1'b1;
        #4;
        check("bp_release_ready", 64'(bus.ready_o), 64'd1);
        if (bus.ready_o) exp_q.push_back(model(PL_R, 64'h80FF_0101_8001_01FF, 64'h0, 8'h00, 4'd3));
        @(negedge clk);
        bus.valid_i = 1'b0;
        #4;
        check("bp_order_2", 64'(bus.trans_id_o), 64'd2);
        @(negedge clk);
        #4;
        check("bp_order_3", 64'(bus.trans_id_o), 64'd3);
        drain();

        // Randomized traffic with random consumer stalls
        rand_rdy = 1'b1;
        tag = 4'd0;
        for (int k = 0; k < 300; k++) begin
            issue(polar_op_t'($urandom_range(0, 2)), {$urandom, $urandom}, {$urandom, $urandom},
                  8'($urandom), tag);
            tag++;
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        drain();

        // Flush with two in flight
        bus.ready_i = 1'b0;
        issue(PL_G, 64'h7070_7070_7070_7070, 64'h7070_7070_7070_7070, 8'h00, 4'd5);
        issue(PL_F, 64'h0102_0304_0506_0708, 64'h0807_0605_0403_0201, 8'h00, 4'd6);
        @(negedge clk);
        bus.flush_i    = 1'b1;
        bus.valid_i    = 1'b1;
        bus.trans_id_i = 4'd7;
        #4;
        check("flush_ready_low", 64'(bus.ready_o), 64'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        exp_q.delete();
        #1;
        check("flush_valid_low", 64'(bus.valid_o), 64'd0);
        bus.ready_i = 1'b1;
        idle(4);
        #1;
        check("flush_no_stale", 64'(bus.valid_o), 64'd0);

        // Reset mid-stream
        bus.ready_i = 1'b0;
        issue(PL_G, 64'h7070_7070_7070_7070, 64'h7070_7070_7070_7070, 8'h00, 4'd8);
        issue(PL_G, 64'h1010_1010_1010_1010, 64'h2020_2020_2020_2020, 8'h00, 4'd9);
        @(negedge clk);
        bus.valid_i = 1'b0;
        #1;
        check("pre_rst_valid", 64'(bus.valid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.valid_o), 64'd0);
        check("mid_rst_result", bus.result_o, 64'd0);
        check("mid_rst_tag", 64'(bus.trans_id_o), 64'd0);
        check("mid_rst_sat", 64'(bus.sat_o), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        #1;
        check("post_rst_valid", 64'(bus.valid_o), 64'd0);

`ifdef POLAR_SAT_CNT_EN
        drain();
        bus.sat_clr_i = 1'b1;
        @(negedge clk);
        bus.sat_clr_i = 1'b0;
        for (int k = 0; k < 4; k++)
            issue(PL_G, 64'h7070_7070_7070_7070, 64'h7070_7070_7070_7070, 8'h00, 4'(k));
        drain();
        #1;
        check("sat_cnt_32", 64'(bus.sat_cnt_o), 64'd32);
        bus.ready_i = 1'b0;
        issue(PL_G, 64'h7070_7070_7070_7070, 64'h7070_7070_7070_7070, 8'h00, 4'd4);
        idle(2);
        @(negedge clk);
        bus.ready_i   = 1'b1;
        bus.sat_clr_i = 1'b1;
        @(negedge clk);
        bus.sat_clr_i = 1'b0;
        #1;
        check("sat_cnt_clr", 64'(bus.sat_cnt_o), 64'd0);
`endif
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
